// File: rtl/mantissa_align_shifter.sv
// Iterative right-shift alignment of an 11-bit half-precision significand.
// Optional guard/round/sticky generation is enabled by defining ALIGN_GRS_EN.
module mantissa_align_shifter #(
    parameter int unsigned MAX_STEP  = 2,
    parameter int unsigned SHAMT_CAP = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_mant,
    input  logic [4:0]  in_shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_mant,
    output logic        out_guard,
    output logic        out_round,
    output logic        out_sticky
);

`ifdef ALIGN_GRS_EN
    localparam int unsigned DW  = 13;
    localparam int unsigned CAP = SHAMT_CAP;
`else
    localparam int unsigned DW  = 11;
    localparam int unsigned CAP = 11;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [3:0]      rem_q, rem_d;
    logic [4:0]      shamt_eff;
    logic [3:0]      step;
`ifdef ALIGN_GRS_EN
    logic            sticky_q, sticky_d;
    logic            shifted_out;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            rem_q    <= '0;
`ifdef ALIGN_GRS_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
`ifdef ALIGN_GRS_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    // Saturate the exponent difference; anything past the cap only feeds sticky.
    always_comb begin
        shamt_eff = in_shamt;
        if ({27'b0, in_shamt} > CAP) begin
            shamt_eff = 5'(CAP);
        end
        step = rem_q;
        if ({28'b0, rem_q} > MAX_STEP) begin
            step = 4'(MAX_STEP);
        end
    end

`ifdef ALIGN_GRS_EN
    always_comb begin
        shifted_out = 1'b0;
        for (int unsigned i = 0; i < MAX_STEP; i++) begin
            if (i < {28'b0, step}) begin
                shifted_out = shifted_out | data_q[i];
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rem_d    = rem_q;
`ifdef ALIGN_GRS_EN
        sticky_d = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ALIGN_GRS_EN
                    data_d   = {in_mant, 2'b00};
                    sticky_d = 1'b0;
`else
                    data_d   = in_mant;
`endif
                    rem_d    = shamt_eff[3:0];
                    state_d  = (shamt_eff == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = data_q >> step;
                rem_d  = rem_q - step;
`ifdef ALIGN_GRS_EN
                sticky_d = sticky_q | shifted_out;
`endif
                if (rem_q == step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        out_mant   = '0;
        out_guard  = 1'b0;
        out_round  = 1'b0;
        out_sticky = 1'b0;
        if (state_q == DONE) begin
`ifdef ALIGN_GRS_EN
            out_mant   = data_q[12:2];
            out_guard  = data_q[1];
            out_round  = data_q[0];
            out_sticky = sticky_q;
`else
            out_mant   = data_q;
`endif
        end
    end

endmodule
